// File: rtl/uni_controle_multiciclo.sv
// Multicycle control FSM for the RV64 datapath: decodes IR and sequences fetch, decode,
// execute, memory and write-back phases, with a memory-latency counter and a sticky illegal-instruction trap.
module uni_controle_multiciclo #(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instrucao,
    input  logic                zero,
    output logic [ALU_OP_W-1:0] estado_ula,
    output logic                escrita_pc,
    output logic                sel_pc,
    output logic                rw_memoria,
    output logic                sel_end,
    output logic                escreve_instr,
    output logic                escreve_a,
    output logic                escreve_b,
    output logic                escreve_aluout,
    output logic                escreve_mdr,
    output logic                escreve_banco,
    output logic                sel_mux_a,
    output logic [1:0]          sel_mux_b,
    output logic [1:0]          sel_wb,
    output logic                excecao,
    output logic [STATE_W-1:0]  estado_atual
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [ALU_OP_W-1:0] ULA_ADD = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ULA_SUB = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ULA_AND = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ULA_OR  = ALU_OP_W'(4);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_BUSCA   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_WB_ALU  = 4'd5,
        S_ADDR    = 4'd6,
        S_MEM_LD  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_MEM_ST  = 4'd9,
        S_BRANCH  = 4'd10,
        S_LUI     = 4'd11,
        S_JAL     = 4'd12,
        S_EXCECAO = 4'd13
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode            = instrucao[6:0];
    assign funct3            = instrucao[14:12];
    assign funct7            = instrucao[31:25];
    assign unused_instr_bits = ^{instrucao[24:15], instrucao[11:7]};
    assign estado_atual      = STATE_W'(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= CNT_RELOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Moore controls; the wait counter is reloaded in every non-waiting state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = CNT_RELOAD;
        estado_ula     = '0;
        escrita_pc     = 1'b0;
        sel_pc         = 1'b0;
        rw_memoria     = 1'b0;
        sel_end        = 1'b0;
        escreve_instr  = 1'b0;
        escreve_a      = 1'b0;
        escreve_b      = 1'b0;
        escreve_aluout = 1'b0;
        escreve_mdr    = 1'b0;
        escreve_banco  = 1'b0;
        sel_mux_a      = 1'b0;
        sel_mux_b      = 2'd0;
        sel_wb         = 2'd0;
        excecao        = 1'b0;

        case (state_q)
            S_RESET: state_d = S_BUSCA;
            S_BUSCA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    escreve_instr = 1'b1;
                    escrita_pc    = 1'b1;
                    sel_mux_b     = 2'd1;
                    estado_ula    = ULA_ADD;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                escreve_a      = 1'b1;
                escreve_b      = 1'b1;
                escreve_aluout = 1'b1;
                sel_mux_b      = 2'd2;
                estado_ula     = ULA_ADD;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_LUI:             state_d = S_LUI;
                    OP_JAL:             state_d = S_JAL;
                    default:            state_d = S_EXCECAO;
                endcase
            end
            S_EXEC_R: begin
                state_d = S_WB_ALU;
                case ({funct7, funct3})
                    10'b0000000_000: estado_ula = ULA_ADD;
                    10'b0100000_000: estado_ula = ULA_SUB;
                    10'b0000000_111: estado_ula = ULA_AND;
                    10'b0000000_110: estado_ula = ULA_OR;
                    default:         state_d    = S_EXCECAO;
                endcase
                if (state_d == S_WB_ALU) begin
                    sel_mux_a      = 1'b1;
                    escreve_aluout = 1'b1;
                end
            end
            S_EXEC_I: begin
                if (funct3 == 3'b000) begin
                    estado_ula     = ULA_ADD;
                    sel_mux_a      = 1'b1;
                    sel_mux_b      = 2'd2;
                    escreve_aluout = 1'b1;
                    state_d        = S_WB_ALU;
                end else begin
                    state_d = S_EXCECAO;
                end
            end
            S_WB_ALU: begin
                escreve_banco = 1'b1;
                state_d       = S_BUSCA;
            end
            S_ADDR: begin
                estado_ula     = ULA_ADD;
                sel_mux_a      = 1'b1;
                sel_mux_b      = 2'd2;
                escreve_aluout = 1'b1;
                state_d        = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
            end
            S_MEM_LD: begin
                sel_end = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    escreve_mdr = 1'b1;
                    state_d     = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                escreve_banco = 1'b1;
                sel_wb        = 2'd1;
                state_d       = S_BUSCA;
            end
            S_MEM_ST: begin
                sel_end    = 1'b1;
                rw_memoria = 1'b1;
                state_d    = S_BUSCA;
            end
            S_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    estado_ula = ULA_SUB;
                    sel_mux_a  = 1'b1;
                    sel_pc     = 1'b1;
                    escrita_pc = (funct3 == 3'b000) ? zero : !zero;
                    state_d    = S_BUSCA;
                end else begin
                    state_d = S_EXCECAO;
                end
            end
            S_LUI: begin
                escreve_banco = 1'b1;
                sel_wb        = 2'd2;
                state_d       = S_BUSCA;
            end
            S_JAL: begin
                escreve_banco = 1'b1;
                sel_wb        = 2'd3;
                escrita_pc    = 1'b1;
                sel_pc        = 1'b1;
                state_d       = S_BUSCA;
            end
            S_EXCECAO: excecao = 1'b1;
            default:   state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_uni_controle_multiciclo.sv
// Bench for uni_controle_multiciclo: MEM_LAT=1 and MEM_LAT=3 instances checked cycle by cycle
// against per-instruction phase traces built from the instruction-class rules.
module tb_uni_controle_multiciclo;

    typedef struct packed {
        logic [2:0] ula;
        logic epc, spc, rw, send, ei, ea, eb, eao, emdr, ebanco, sma;
        logic [1:0] smb, swb;
        logic exc;
    } ctl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctl_t        c;
        logic [31:0] ins;
        logic        z;
    } rec_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       c;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] instr1 = '0, instr3 = '0;
    logic zero1 = 1'b0, zero3 = 1'b0;

    logic [2:0] ula1, ula3;
    logic epc1, spc1, rw1, send1, ei1, ea1, eb1, eao1, emdr1, ebk1, sma1, exc1;
    logic epc3, spc3, rw3, send3, ei3, ea3, eb3, eao3, emdr3, ebk3, sma3, exc3;
    logic [1:0] smb1, swb1, smb3, swb3;
    logic [3:0] st1, st3;
    ctl_t o1, o3;

    assign o1 = {ula1, epc1, spc1, rw1, send1, ei1, ea1, eb1, eao1, emdr1, ebk1, sma1, smb1, swb1, exc1};
    assign o3 = {ula3, epc3, spc3, rw3, send3, ei3, ea3, eb3, eao3, emdr3, ebk3, sma3, smb3, swb3, exc3};

    always #5 clk = ~clk;

    uni_controle_multiciclo #(.MEM_LAT(1), .ALU_OP_W(3), .STATE_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .instrucao(instr1), .zero(zero1),
        .estado_ula(ula1), .escrita_pc(epc1), .sel_pc(spc1), .rw_memoria(rw1), .sel_end(send1),
        .escreve_instr(ei1), .escreve_a(ea1), .escreve_b(eb1), .escreve_aluout(eao1),
        .escreve_mdr(emdr1), .escreve_banco(ebk1), .sel_mux_a(sma1), .sel_mux_b(smb1),
        .sel_wb(swb1), .excecao(exc1), .estado_atual(st1)
    );

    uni_controle_multiciclo #(.MEM_LAT(3), .ALU_OP_W(3), .STATE_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .instrucao(instr3), .zero(zero3),
        .estado_ula(ula3), .escrita_pc(epc3), .sel_pc(spc3), .rw_memoria(rw3), .sel_end(send3),
        .escreve_instr(ei3), .escreve_a(ea3), .escreve_b(eb3), .escreve_aluout(eao3),
        .escreve_mdr(emdr3), .escreve_banco(ebk3), .sel_mux_a(sma3), .sel_mux_b(smb3),
        .sel_wb(swb3), .excecao(exc3), .estado_atual(st3)
    );

    int checks = 0;
    int errors = 0;
    rec_t q1[$], q3[$];
    obs_t obs1[$], obs3[$];

    // Phase codes used by the debug output
    localparam logic [3:0] P_RESET = 4'd0, P_FETCH = 4'd1, P_DEC = 4'd2, P_EXR = 4'd3, P_EXI = 4'd4,
                           P_WBA = 4'd5, P_ADDR = 4'd6, P_MLD = 4'd7, P_WBM = 4'd8, P_MST = 4'd9,
                           P_BR = 4'd10, P_LUI = 4'd11, P_JAL = 4'd12, P_EXC = 4'd13;

    task automatic push(input int lat, input logic [3:0] st, input ctl_t c, input logic [31:0] ins, input logic z);
        rec_t r;
        r.st = st; r.c = c; r.ins = ins; r.z = z;
        if (lat == 1) q1.push_back(r); else q3.push_back(r);
    endtask

    // Expected per-cycle trace of one instruction, from fetch to its last phase.
    task automatic gen(input logic [31:0] ins, input logic z, input int lat);
        ctl_t c;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int aop;
        bit trap;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; trap = 0;
        for (int i = 0; i < lat - 1; i++) push(lat, P_FETCH, '0, ins, z);
        c = '0; c.ula = 3'd1; c.epc = 1; c.ei = 1; c.smb = 2'd1; push(lat, P_FETCH, c, ins, z);
        c = '0; c.ea = 1; c.eb = 1; c.eao = 1; c.ula = 3'd1; c.smb = 2'd2; push(lat, P_DEC, c, ins, z);
        case (op)
            7'h33: begin
                aop = (f7 == 7'h00 && f3 == 3'd0) ? 1 : (f7 == 7'h20 && f3 == 3'd0) ? 2 :
                      (f7 == 7'h00 && f3 == 3'd7) ? 3 : (f7 == 7'h00 && f3 == 3'd6) ? 4 : 0;
                if (aop != 0) begin
                    c = '0; c.ula = 3'(aop); c.sma = 1; c.eao = 1; push(lat, P_EXR, c, ins, z);
                    c = '0; c.ebanco = 1; push(lat, P_WBA, c, ins, z);
                end else begin
                    push(lat, P_EXR, '0, ins, z); trap = 1;
                end
            end
            7'h13: begin
                if (f3 == 3'd0) begin
                    c = '0; c.ula = 3'd1; c.sma = 1; c.smb = 2'd2; c.eao = 1; push(lat, P_EXI, c, ins, z);
                    c = '0; c.ebanco = 1; push(lat, P_WBA, c, ins, z);
                end else begin
                    push(lat, P_EXI, '0, ins, z); trap = 1;
                end
            end
            7'h03, 7'h23: begin
                c = '0; c.ula = 3'd1; c.sma = 1; c.smb = 2'd2; c.eao = 1; push(lat, P_ADDR, c, ins, z);
                if (op == 7'h03) begin
                    for (int i = 0; i < lat - 1; i++) begin
                        c = '0; c.send = 1; push(lat, P_MLD, c, ins, z);
                    end
                    c = '0; c.send = 1; c.emdr = 1; push(lat, P_MLD, c, ins, z);
                    c = '0; c.ebanco = 1; c.swb = 2'd1; push(lat, P_WBM, c, ins, z);
                end else begin
                    c = '0; c.send = 1; c.rw = 1; push(lat, P_MST, c, ins, z);
                end
            end
            7'h63: begin
                if (f3 == 3'd0 || f3 == 3'd1) begin
                    c = '0; c.ula = 3'd2; c.sma = 1; c.spc = 1; c.epc = (f3 == 3'd0) ? z : !z;
                    push(lat, P_BR, c, ins, z);
                end else begin
                    push(lat, P_BR, '0, ins, z); trap = 1;
                end
            end
            7'h37: begin c = '0; c.ebanco = 1; c.swb = 2'd2; push(lat, P_LUI, c, ins, z); end
            7'h6f: begin c = '0; c.ebanco = 1; c.swb = 2'd3; c.epc = 1; c.spc = 1; push(lat, P_JAL, c, ins, z); end
            default: trap = 1;
        endcase
        if (trap) begin
            c = '0; c.exc = 1;
            for (int i = 0; i < 22; i++) push(lat, P_EXC, c, ins, z);
        end
    endtask

    task automatic gen_both(input logic [31:0] ins, input logic z);
        gen(ins, z, 1);
        gen(ins, z, 3);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = op; r[14:12] = f3; r[31:25] = f7;
        return r;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [6:0] rf7;
        logic [2:0] rf3;
        rf7 = 7'($urandom); rf3 = 3'($urandom);
        case ($urandom_range(0, 6))
            0: case ($urandom_range(0, 3))
                   0: return mk(7'h33, 3'd0, 7'h00);
                   1: return mk(7'h33, 3'd0, 7'h20);
                   2: return mk(7'h33, 3'd7, 7'h00);
                   default: return mk(7'h33, 3'd6, 7'h00);
               endcase
            1: return mk(7'h13, 3'd0, rf7);
            2: return mk(7'h03, 3'd3, rf7);
            3: return mk(7'h23, 3'd3, rf7);
            4: return mk(7'h63, 3'($urandom_range(0, 1)), rf7);
            5: return mk(7'h37, rf3, rf7);
            default: return mk(7'h6f, rf3, rf7);
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        q1.delete(); q3.delete();
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives each instance from its own trace and records what it shows mid-cycle.
    task automatic run(input int n);
        obs1.delete(); obs3.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i < q1.size()) begin instr1 = q1[i].ins; zero1 = q1[i].z; end
            if (i < q3.size()) begin instr3 = q3[i].ins; zero3 = q3[i].z; end
            @(negedge clk);
            obs1.push_back({st1, o1});
            obs3.push_back({st3, o3});
        end
    endtask

    function automatic int longest();
        return (q1.size() > q3.size()) ? q1.size() : q3.size();
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({st1, o1} !== '0 || {st3, o3} !== '0) begin
            errors++;
            $display("FAIL reset_state st1=%0d o1=%h st3=%0d o3=%h expected all 0", st1, o1, st3, o3);
        end
        gen_both(32'h002081B3, 1'b0);
        run(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs1[i] !== {q1[i].st, q1[i].c}) begin
                errors++;
                $display("FAIL reset_pre lat1 cyc%0d got %h expected %h", i, obs1[i], {q1[i].st, q1[i].c});
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({st1, o1} !== '0 || {st3, o3} !== '0) begin
            errors++;
            $display("FAIL reset_async st1=%0d o1=%h st3=%0d o3=%h expected all 0", st1, o1, st3, o3);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (st1 !== P_FETCH || st3 !== P_FETCH) begin
            errors++;
            $display("FAIL reset_release st1=%0d st3=%0d expected %0d", st1, st3, P_FETCH);
        end
    endtask

    task automatic test_r_type();
        do_reset();
        gen_both(32'h002081B3, 1'b0);
        gen_both(32'h402081B3, 1'b1);
        gen_both(mk(7'h33, 3'd7, 7'h00), 1'b0);
        gen_both(mk(7'h33, 3'd6, 7'h00), 1'b0);
        gen_both(mk(7'h13, 3'd0, 7'($urandom)), 1'b0);
        run(longest());
        for (int i = 0; i < q1.size(); i++) begin
            checks++;
            if (obs1[i] !== {q1[i].st, q1[i].c}) begin
                errors++;
                $display("FAIL r_type lat1 cyc%0d got %h expected %h", i, obs1[i], {q1[i].st, q1[i].c});
            end
        end
        for (int i = 0; i < q3.size(); i++) begin
            checks++;
            if (obs3[i] !== {q3[i].st, q3[i].c}) begin
                errors++;
                $display("FAIL r_type lat3 cyc%0d got %h expected %h", i, obs3[i], {q3[i].st, q3[i].c});
            end
        end
    endtask

    task automatic test_load_store();
        int n_mdr, n_mld, n_fetch, n_rw, n_bank;
        do_reset();
        gen_both(32'h0080B283, 1'b0);
        gen_both(32'h0050B423, 1'b0);
        run(longest());
        n_mdr = 0; n_mld = 0; n_fetch = 0; n_rw = 0; n_bank = 0;
        for (int i = 0; i < q3.size(); i++) begin
            checks++;
            if (obs3[i] !== {q3[i].st, q3[i].c}) begin
                errors++;
                $display("FAIL ldst lat3 cyc%0d got %h expected %h", i, obs3[i], {q3[i].st, q3[i].c});
            end
            if (i < 9) begin
                n_mdr += int'(obs3[i].c.emdr);
                n_mld += int'(obs3[i].st == P_MLD && obs3[i].c.send);
                n_fetch += int'(obs3[i].st == P_FETCH);
            end else begin
                n_rw += int'(obs3[i].c.rw);
                n_bank += int'(obs3[i].c.ebanco);
            end
        end
        for (int i = 0; i < q1.size(); i++) begin
            checks++;
            if (obs1[i] !== {q1[i].st, q1[i].c}) begin
                errors++;
                $display("FAIL ldst lat1 cyc%0d got %h expected %h", i, obs1[i], {q1[i].st, q1[i].c});
            end
        end
        checks++;
        if (n_mdr != 1 || n_mld != 3 || n_fetch != 3) begin
            errors++;
            $display("FAIL load_lat3 mdr=%0d mem_ld=%0d fetch=%0d expected 1 3 3", n_mdr, n_mld, n_fetch);
        end
        checks++;
        if (n_rw != 1 || n_bank != 0) begin
            errors++;
            $display("FAIL store_lat3 rw=%0d banco=%0d expected 1 0", n_rw, n_bank);
        end
    endtask

    task automatic test_branch();
        do_reset();
        gen_both(mk(7'h63, 3'd0, 7'($urandom)), 1'b1);
        gen_both(mk(7'h63, 3'd0, 7'($urandom)), 1'b0);
        gen_both(mk(7'h63, 3'd1, 7'($urandom)), 1'b1);
        gen_both(mk(7'h63, 3'd1, 7'($urandom)), 1'b0);
        gen_both(mk(7'h37, 3'($urandom), 7'($urandom)), 1'b0);
        gen_both(mk(7'h6f, 3'($urandom), 7'($urandom)), 1'b1);
        run(longest());
        for (int i = 0; i < q1.size(); i++) begin
            checks++;
            if (obs1[i] !== {q1[i].st, q1[i].c}) begin
                errors++;
                $display("FAIL branch lat1 cyc%0d got %h expected %h", i, obs1[i], {q1[i].st, q1[i].c});
            end
        end
        for (int i = 0; i < q3.size(); i++) begin
            checks++;
            if (obs3[i] !== {q3[i].st, q3[i].c}) begin
                errors++;
                $display("FAIL branch lat3 cyc%0d got %h expected %h", i, obs3[i], {q3[i].st, q3[i].c});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ins = rand_legal();
            gen_both(ins, 1'($urandom));
        end
        run(longest());
        for (int i = 0; i < q1.size(); i++) begin
            checks++;
            if (obs1[i] !== {q1[i].st, q1[i].c}) begin
                errors++;
                $display("FAIL b2b lat1 cyc%0d ins=%h got %h expected %h", i, q1[i].ins, obs1[i], {q1[i].st, q1[i].c});
            end
        end
        for (int i = 0; i < q3.size(); i++) begin
            checks++;
            if (obs3[i] !== {q3[i].st, q3[i].c}) begin
                errors++;
                $display("FAIL b2b lat3 cyc%0d ins=%h got %h expected %h", i, q3[i].ins, obs3[i], {q3[i].st, q3[i].c});
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [4];
        int n_exc;
        bad[0] = 32'h0000007F;
        bad[1] = 32'h022081B3;
        bad[2] = mk(7'h13, 3'($urandom_range(1, 7)), 7'($urandom));
        bad[3] = mk(7'h63, 3'($urandom_range(2, 7)), 7'($urandom));
        for (int b = 0; b < 4; b++) begin
            do_reset();
            gen_both(rand_legal(), 1'($urandom));
            gen_both(bad[b], 1'($urandom));
            run(longest());
            n_exc = 0;
            for (int i = 0; i < q1.size(); i++) begin
                checks++;
                if (obs1[i] !== {q1[i].st, q1[i].c}) begin
                    errors++;
                    $display("FAIL illegal%0d lat1 cyc%0d got %h expected %h", b, i, obs1[i], {q1[i].st, q1[i].c});
                end
                n_exc += int'(obs1[i].c.exc);
            end
            for (int i = 0; i < q3.size(); i++) begin
                checks++;
                if (obs3[i] !== {q3[i].st, q3[i].c}) begin
                    errors++;
                    $display("FAIL illegal%0d lat3 cyc%0d got %h expected %h", b, i, obs3[i], {q3[i].st, q3[i].c});
                end
            end
            checks++;
            if (n_exc < 20 || exc1 !== 1'b1 || exc3 !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d_sticky cycles=%0d exc1=%b exc3=%b expected >=20 1 1", b, n_exc, exc1, exc3);
            end
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (exc1 !== 1'b0 || exc3 !== 1'b0 || st1 !== P_RESET || st3 !== P_RESET) begin
            errors++;
            $display("FAIL illegal_clear exc1=%b exc3=%b st1=%0d st3=%0d expected 0 0 0 0", exc1, exc3, st1, st3);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
